// File: rtl/keypad_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_if
// Brief    : Keypad header bundle: row sense lines in, column strobes and the
//            decoded key report out.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_scan_if;
    logic [3:0] row_in;     // active-low rows, asynchronous to clk
    logic [3:0] col_out;    // active-low one-hot column strobes
    logic [3:0] key_code;   // row*4 + col of the last accepted key
    logic       key_valid;  // one-cycle pulse on an accepted press
    logic       key_down;   // high while the accepted key is held

    // Board/consumer side: drives the rows, observes the scanner
    modport master (
        output row_in,
        input  col_out, key_code, key_valid, key_down
    );

    // Scanner side
    modport slave (
        input  row_in,
        output col_out, key_code, key_valid, key_down
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan
// Brief    : 4x4 matrix keypad scanner. Strobes one column at a time, samples
//            the synchronized rows at the end of each dwell, debounces the
//            first pressed key found and reports it with a one-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan #(
    parameter int SCAN_DIV     = 1000,    // cycles per column dwell, >= 4
    parameter int DEBOUNCE_CNT = 200000   // stable cycles for press/release, >= 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    keypad_scan_if.slave  kp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT);

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CNT - 1);

    localparam logic [1:0] c_st_scan     = 2'd0;
    localparam logic [1:0] c_st_debounce = 2'd1;
    localparam logic [1:0] c_st_held     = 2'd2;
    localparam logic [1:0] c_st_release  = 2'd3;

    logic [3:0]       r_sync1, r_sync2;
    logic [1:0]       r_state,     w_state_nxt;
    logic [1:0]       r_col,       w_col_nxt;
    logic [DIV_W-1:0] r_div,       w_div_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [1:0]       r_cand_row,  w_cand_row_nxt;
    logic [3:0]       r_col_out,   w_col_out_nxt;
    logic [3:0]       r_key_code,  w_key_code_nxt;
    logic             r_key_valid, w_key_valid_nxt;
    logic             r_key_down,  w_key_down_nxt;

    logic [3:0]       w_row_lo;
    logic             w_cand_lo;

    // Rows are active low; invert once so the FSM reasons in "pressed" terms
    assign w_row_lo  = ~r_sync2;
    // The candidate row is the only row watched once a key is being tracked
    assign w_cand_lo = w_row_lo[r_cand_row];

    // Two-flop synchronizer for the asynchronous row lines (idle = pulled up)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= kp.row_in;
            r_sync2 <= r_sync1;
        end
    end

    // Scan/debounce state register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_scan;
            r_col       <= 2'd0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_cand_row  <= 2'd0;
            r_col_out   <= 4'b1110;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_div       <= w_div_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cand_row  <= w_cand_row_nxt;
            r_col_out   <= w_col_out_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_down  <= w_key_down_nxt;
        end
    end

    // Next-state logic: column dwell, candidate capture, press/release debounce
    always_comb begin
        w_state_nxt     = r_state;
        w_col_nxt       = r_col;
        w_div_nxt       = r_div;
        w_cnt_nxt       = r_cnt;
        w_cand_row_nxt  = r_cand_row;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = 1'b0;
        w_key_down_nxt  = r_key_down;

        case (r_state)
            c_st_scan: begin
                if (r_div == c_div_last) begin
                    // Dwell counter restarts whether we advance or freeze
                    w_div_nxt = '0;
                    if (|w_row_lo) begin
                        w_state_nxt = c_st_debounce;
                        w_cnt_nxt   = '0;
                        // Lowest-indexed pressed row wins
                        if (w_row_lo[0])      w_cand_row_nxt = 2'd0;
                        else if (w_row_lo[1]) w_cand_row_nxt = 2'd1;
                        else if (w_row_lo[2]) w_cand_row_nxt = 2'd2;
                        else                  w_cand_row_nxt = 2'd3;
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            c_st_debounce: begin
                if (!w_cand_lo) begin
                    // Bounce or glitch: abandon candidate, resume at next column
                    w_state_nxt = c_st_scan;
                    w_col_nxt   = r_col + 2'd1;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt     = c_st_held;
                    w_key_code_nxt  = {r_cand_row, r_col};
                    w_key_valid_nxt = 1'b1;
                    w_key_down_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            c_st_held: begin
                if (!w_cand_lo) begin
                    w_state_nxt = c_st_release;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_release: begin
                if (w_cand_lo) begin
                    // Release bounce: key is still held, no new report
                    w_state_nxt = c_st_held;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt    = c_st_scan;
                    w_key_down_nxt = 1'b0;
                    w_col_nxt      = r_col + 2'd1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_st_scan;
            end
        endcase

        // Strobe register follows the next column so col_out is glitch-free
        w_col_out_nxt            = 4'b1111;
        w_col_out_nxt[w_col_nxt] = 1'b0;
    end

    assign kp.col_out   = r_col_out;
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_down  = r_key_down;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan
// Brief    : Directed self-checking bench for keypad_scan with a behavioural
//            4x4 key matrix (SCAN_DIV=8, DEBOUNCE_CNT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key_mat;     // bit r*4+c set = key at row r, column c pressed
    logic [3:0]  glitch_low;  // extra raw lows forced onto rows
    logic [3:0]  row_model;
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          pulse_cnt = 0;
    int          p0;
    bit          hold_ok;
    logic [3:0]  col_seq [5];

    keypad_scan_if kp_if ();

    keypad_scan #(
        .SCAN_DIV     (8),
        .DEBOUNCE_CNT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_if.slave)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its row low while its column is strobed
    always_comb begin
        row_model = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mat[r*4+c] && !kp_if.col_out[c]) row_model[r] = 1'b0;
        row_model = row_model & ~glitch_low;
    end
    assign kp_if.row_in = row_model;

    // Count every key_valid cycle
    always @(posedge clk) begin
        if (kp_if.key_valid) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (kp_if.key_valid) seen = 1'b1;
        end
        check_val({tag, "_valid_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_col(input string tag, input logic [3:0] col, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (kp_if.col_out == col) seen = 1'b1;
        end
        check_val({tag, "_col_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_down_low(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (!kp_if.key_down) seen = 1'b1;
        end
        check_val({tag, "_down_low"}, 32'(seen), 32'd1);
    endtask

    initial begin
        col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011;
        col_seq[3] = 4'b0111; col_seq[4] = 4'b1110;
        rst = 1'b1; key_mat = '0; glitch_low = '0;

        // Reset state and idle scan
        repeat (3) @(negedge clk);
        check_val("rst_col",   32'(kp_if.col_out),   32'hE);
        check_val("rst_code",  32'(kp_if.key_code),  32'h0);
        check_val("rst_valid", 32'(kp_if.key_valid), 32'h0);
        check_val("rst_down",  32'(kp_if.key_down),  32'h0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            repeat (4) @(negedge clk);
            check_val($sformatf("idle_col%0d", k), 32'(kp_if.col_out), 32'(col_seq[k]));
            repeat (4) @(negedge clk);
        end
        check_val("idle_pulses", 32'(pulse_cnt), 32'd0);
        check_val("idle_down",   32'(kp_if.key_down), 32'd0);

        // Row 2 / column 1 held, then released: code 9
        p0 = pulse_cnt;
        key_mat[9] = 1'b1;
        wait_valid("k9", 80);
        check_val("k9_code", 32'(kp_if.key_code), 32'd9);
        check_val("k9_down", 32'(kp_if.key_down), 32'd1);
        check_val("k9_col",  32'(kp_if.col_out),  32'hD);
        hold_ok = 1'b1;
        repeat (150) begin
            @(negedge clk);
            if (kp_if.col_out != 4'b1101 || !kp_if.key_down) hold_ok = 1'b0;
        end
        check_val("k9_hold", 32'(hold_ok), 32'd1);
        key_mat[9] = 1'b0;
        repeat (18) @(negedge clk);
        check_val("k9_down_before", 32'(kp_if.key_down), 32'd1);
        check_val("k9_col_before",  32'(kp_if.col_out),  32'hD);
        @(negedge clk);
        check_val("k9_down_after", 32'(kp_if.key_down), 32'd0);
        check_val("k9_col_after",  32'(kp_if.col_out),  32'hB);
        check_val("k9_pulses", 32'(pulse_cnt - p0), 32'd1);

        // Short glitch on row 0 during column 3 is rejected
        p0 = pulse_cnt;
        wait_col("gl", 4'b0111, 40);
        repeat (2) @(negedge clk);
        glitch_low = 4'b0001;
        repeat (5) @(negedge clk);
        glitch_low = 4'b0000;
        @(negedge clk);
        check_val("gl_frozen", 32'(kp_if.col_out), 32'h7);
        repeat (5) @(negedge clk);
        check_val("gl_col",    32'(kp_if.col_out),  32'hE);
        check_val("gl_code",   32'(kp_if.key_code), 32'd9);
        check_val("gl_pulses", 32'(pulse_cnt - p0), 32'd0);

        // Rows 1 and 3 in column 0: lowest row wins, code 4
        p0 = pulse_cnt;
        key_mat[4] = 1'b1; key_mat[12] = 1'b1;
        wait_valid("k4", 60);
        check_val("k4_code", 32'(kp_if.key_code), 32'd4);
        @(negedge clk);
        check_val("k4_one_cycle", 32'(kp_if.key_valid), 32'd0);
        repeat (40) @(negedge clk);
        check_val("k4_pulses", 32'(pulse_cnt - p0), 32'd1);
        key_mat[4] = 1'b0; key_mat[12] = 1'b0;
        wait_down_low("k4", 40);

        // Release bounce on row 0 / column 2 (code 2)
        p0 = pulse_cnt;
        key_mat[2] = 1'b1;
        wait_valid("k2", 80);
        check_val("k2_code", 32'(kp_if.key_code), 32'd2);
        repeat (10) @(negedge clk);
        key_mat[2] = 1'b0;
        repeat (6) @(negedge clk);
        key_mat[2] = 1'b1;
        repeat (3) @(negedge clk);
        key_mat[2] = 1'b0;
        repeat (18) @(negedge clk);
        check_val("k2_down_before", 32'(kp_if.key_down), 32'd1);
        @(negedge clk);
        check_val("k2_down_after", 32'(kp_if.key_down), 32'd0);
        check_val("k2_pulses", 32'(pulse_cnt - p0), 32'd1);

        // Reset during DEBOUNCE of row 1 / column 3 (code 7)
        wait_col("rd", 4'b1110, 40);
        key_mat[7] = 1'b1;
        wait_col("rd", 4'b0111, 40);
        repeat (12) @(negedge clk);
        p0 = pulse_cnt;
        rst = 1'b1;
        #1;
        check_val("rd_col",   32'(kp_if.col_out),   32'hE);
        check_val("rd_code",  32'(kp_if.key_code),  32'd0);
        check_val("rd_valid", 32'(kp_if.key_valid), 32'd0);
        check_val("rd_down",  32'(kp_if.key_down),  32'd0);
        repeat (3) @(negedge clk);
        check_val("rd_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        rst = 1'b0;
        wait_valid("rd_redetect", 80);
        check_val("rd_code_after", 32'(kp_if.key_code), 32'd7);

        // Reset during HELD, then re-detection of the same key
        repeat (5) @(negedge clk);
        check_val("rh_down_pre", 32'(kp_if.key_down), 32'd1);
        p0 = pulse_cnt;
        rst = 1'b1;
        #1;
        check_val("rh_col",   32'(kp_if.col_out),   32'hE);
        check_val("rh_code",  32'(kp_if.key_code),  32'd0);
        check_val("rh_valid", 32'(kp_if.key_valid), 32'd0);
        check_val("rh_down",  32'(kp_if.key_down),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_valid("rh_redetect", 80);
        check_val("rh_code_after", 32'(kp_if.key_code), 32'd7);
        @(negedge clk);
        check_val("rh_pulses", 32'(pulse_cnt - p0), 32'd1);
        key_mat[7] = 1'b0;
        wait_down_low("rh", 40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
